// File: rtl/pipe_pkg.sv
// Shared Execute-stage definitions: datapath width, operand-mux channel indices
// and the packing helper used when a beat travels through a skid stage.
package pipe_pkg;

    localparam int DATA_W = 32;

    localparam int SEL_RS      = 0;
    localparam int SEL_FWD_MEM = 1;
    localparam int SEL_FWD_WB  = 2;
    localparam int SEL_IMM     = 3;

    // Width of one {err, sel, data} beat.
    function automatic int beat_w(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Operand-select bus: producer side (in_*) and consumer side (out_*) with
// valid/ready handshakes on both.
interface mux_n_pipe_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_n_pipe_skid_buf.sv
// Generic 2-entry valid/ready register stage. The main entry drives the output;
// the skid entry absorbs the beat accepted in the cycle the consumer stalls.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && !skid_valid_q && !flush;
    assign out_data  = main_data_q;
    assign out_valid = main_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || out_ready) begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = in_data;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/mux_n_pipe.sv
// N:1 Execute operand select with range check, registered through a skid stage.
// Out-of-range selects pass through as zero data with the error flag set.
module mux_n_pipe
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mux_n_pipe_if.slave   bus
);
    localparam int SEL_W = $clog2(N);
    localparam int PW    = beat_w(WIDTH, SEL_W);

    logic [WIDTH-1:0] chan [N];
    logic [N-1:0]     hit;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [PW-1:0]    beat_out;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        assign hit[gi]  = (bus.in_sel == SEL_W'(gi));
    end

    // hit is one-hot or empty; an empty vector means the index is out of range.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (hit[k]) begin
                sel_data = chan[k];
            end
        end
    end

    assign sel_err = ~|hit;

    skid_buf #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   ({sel_err, bus.in_sel, sel_data}),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (beat_out),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign {bus.out_err, bus.out_sel, bus.out_data} = beat_out;
endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: an N=4 and an N=3 instance share stimulus and are
// compared every cycle against queue models, plus hand-computed expectations.
module tb_mux_n_pipe;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_sel = 2'd0;
    logic [31:0] ch [4];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
        logic        e;
    } beat_t;

    beat_t       q4[$];
    beat_t       q3[$];
    logic [31:0] fire_log[$];
    logic        push4, push3;

    always #5 clk = ~clk;

    mux_n_pipe_if #(.WIDTH(DATA_W), .N(4)) if4();
    mux_n_pipe_if #(.WIDTH(DATA_W), .N(3)) if3();

    assign if4.in_data   = {ch[3], ch[2], ch[1], ch[0]};
    assign if4.in_sel    = in_sel;
    assign if4.in_valid  = in_valid;
    assign if4.out_ready = out_ready;
    assign if3.in_data   = {ch[2], ch[1], ch[0]};
    assign if3.in_sel    = in_sel;
    assign if3.in_valid  = in_valid;
    assign if3.out_ready = out_ready;

    mux_n_pipe #(.WIDTH(DATA_W), .N(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if4)
    );
    mux_n_pipe #(.WIDTH(DATA_W), .N(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if3)
    );

    function automatic beat_t mk(input int n, input logic [1:0] s);
        beat_t b;
        b.s = s;
        b.e = (int'(s) >= n);
        b.d = b.e ? 32'h0 : ch[s];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: two-beat occupancy; accept only while fewer than two beats are held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q4.delete();
            q3.delete();
        end else if (flush) begin
            q4.delete();
            q3.delete();
        end else begin
            push4 = in_valid && (q4.size() < 2);
            push3 = in_valid && (q3.size() < 2);
            if (q4.size() > 0 && out_ready) void'(q4.pop_front());
            if (q3.size() > 0 && out_ready) void'(q3.pop_front());
            if (push4) q4.push_back(mk(4, in_sel));
            if (push3) q3.push_back(mk(3, in_sel));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("u4.in_ready", 64'(if4.in_ready), 64'(q4.size() < 2));
            chk("u4.out_valid", 64'(if4.out_valid), 64'(q4.size() > 0));
            if (q4.size() > 0) begin
                chk("u4.out_data", 64'(if4.out_data), 64'(q4[0].d));
                chk("u4.out_sel", 64'(if4.out_sel), 64'(q4[0].s));
                chk("u4.out_err", 64'(if4.out_err), 64'(q4[0].e));
            end
            chk("u3.in_ready", 64'(if3.in_ready), 64'(q3.size() < 2));
            chk("u3.out_valid", 64'(if3.out_valid), 64'(q3.size() > 0));
            if (q3.size() > 0) begin
                chk("u3.out_data", 64'(if3.out_data), 64'(q3[0].d));
                chk("u3.out_sel", 64'(if3.out_sel), 64'(q3[0].s));
                chk("u3.out_err", 64'(if3.out_err), 64'(q3[0].e));
            end
            if (if4.out_valid && out_ready) fire_log.push_back(if4.out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input logic [31:0] base);
        for (int k = 0; k < 4; k++) ch[k] = base + 32'(k);
    endtask

    initial begin
        logic [31:0] bp_exp [6];
        int          idx;
        int          cyc;
        logic        rdy;
        logic        hold;

        set_ch(32'hA0);
        step();
        step();
        chk("rst.out_valid", 64'(if4.out_valid), 64'd0);
        chk("rst.in_ready", 64'(if4.in_ready), 64'd1);
        chk("rst.out_data", 64'(if4.out_data), 64'd0);
        chk("rst.out_sel", 64'(if4.out_sel), 64'd0);
        chk("rst.out_err", 64'(if3.out_err), 64'd0);
        rst = 1'b0;
        step();

        // Stream 0,1,2,3 then 1 with out_ready held high.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_sel   = (k == 4) ? 2'd1 : 2'(k);
            step();
            chk("stream.valid", 64'(if4.out_valid), 64'd1);
            chk("stream.data", 64'(if4.out_data), (k == 4) ? 64'hA1 : 64'(32'hA0 + 32'(k)));
            if (k == 3) begin
                chk("oor.err", 64'(if3.out_err), 64'd1);
                chk("oor.data", 64'(if3.out_data), 64'd0);
                chk("oor.sel", 64'(if3.out_sel), 64'd3);
            end
            if (k == 4) begin
                chk("inr.err", 64'(if3.out_err), 64'd0);
                chk("inr.data", 64'(if3.out_data), 64'hA1);
            end
        end
        in_valid = 1'b0;
        step();
        chk("stream.drain", 64'(if4.out_valid), 64'd0);

        // Backpressure: out_ready low for three cycles while six beats stream.
        bp_exp = '{32'h0A0, 32'h1A1, 32'h2A2, 32'h3A3, 32'h4A0, 32'h5A1};
        fire_log.delete();
        idx = 0;
        cyc = 0;
        while ((idx < 6 || q4.size() > 0) && cyc < 40) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (idx < 6);
            in_sel    = 2'(idx % 4);
            set_ch(32'h100 * 32'(idx) + 32'hA0);
            rdy = (q4.size() < 2);
            step();
            if (in_valid && rdy) idx++;
            if (cyc == 2) begin
                chk("bp.in_ready_low", 64'(if4.in_ready), 64'd0);
                chk("bp.held_data", 64'(if4.out_data), 64'h1A1);
            end
            if (cyc == 3) chk("bp.stable_data", 64'(if4.out_data), 64'h1A1);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp.timeout", 64'(cyc < 40), 64'd1);
        chk("bp.count", 64'(fire_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < fire_log.size(); k++)
            chk("bp.order", 64'(fire_log[k]), 64'(bp_exp[k]));

        // Flush with both registers full and a beat on offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        set_ch(32'h700);
        step();
        set_ch(32'h800);
        step();
        chk("flush.full", 64'(if4.in_ready), 64'd0);
        flush = 1'b1;
        set_ch(32'hDEAD0000);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.out_valid", 64'(if4.out_valid), 64'd0);
        chk("flush.in_ready", 64'(if4.in_ready), 64'd1);
        chk("flush.u3_valid", 64'(if3.out_valid), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("flush.dropped", 64'(if4.out_valid), 64'd0);

        // Asynchronous reset with two beats held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        set_ch(32'h900);
        step();
        set_ch(32'hA00);
        step();
        chk("arst.pre_full", 64'(if4.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(if4.out_valid), 64'd0);
        chk("arst.in_ready", 64'(if4.in_ready), 64'd1);
        chk("arst.out_data", 64'(if4.out_data), 64'd0);
        chk("arst.u3_valid", 64'(if3.out_valid), 64'd0);
        in_valid = 1'b0;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        set_ch(32'hA0);
        step();
        chk("arst.first_valid", 64'(if4.out_valid), 64'd1);
        chk("arst.first_data", 64'(if4.out_data), 64'hA1);
        in_valid = 1'b0;
        step();

        // Random traffic; producer holds an offered beat until it is taken.
        hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) ch[k] = $urandom;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            rdy = (q4.size() < 2);
            step();
            hold = in_valid && !rdy && !flush;
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
